record_play_ctrl: RTL

- Sequencing controller for the note-recording memory: turns user button pulses into that memory's write_en / read_en / read_rst / rst_n controls.
- Runs an idle/record/play/pause state machine and tracks the playback position. It mirrors the memory's per-note sample interval, so end of song is detected exactly and optional looping works.
- Sits between the debounced keypad/button front end and the memory. Its play position feeds the display.

---
 rtl/record_play_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/record_play_ctrl.sv
// Record/playback sequencer for the note memory: turns button pulses into
// memory controls and tracks the play position in lockstep with the memory.
module record_play_ctrl #(
  parameter int DEPTH_BIT       = 8,
  parameter int MAX_DEPTH       = 255,
  parameter int SAMPLE_INTERVAL = 25000000,
  parameter int SI_BIT          = 25
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rec_btn,
  input  logic                 play_btn,
  input  logic                 stop_btn,
  input  logic                 clear_btn,
  input  logic                 loop_en,
  input  logic [DEPTH_BIT-1:0] mem_duration,
  output logic                 mem_write_en,
  output logic                 mem_read_en,
  output logic                 mem_read_rst,
  output logic                 mem_clear_n,
  output logic [2:0]           state,
  output logic [DEPTH_BIT-1:0] play_pos,
  output logic                 rec_full,
  output logic                 play_done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RECORD = 3'd1;
  localparam logic [2:0] S_REWIND = 3'd2;
  localparam logic [2:0] S_PLAY   = 3'd3;
  localparam logic [2:0] S_PAUSE  = 3'd4;
  localparam logic [2:0] S_CLEAR  = 3'd5;

  localparam logic [DEPTH_BIT-1:0] MAX_D = DEPTH_BIT'(MAX_DEPTH);
  localparam logic [SI_BIT-1:0]    SI_V  = SI_BIT'(SAMPLE_INTERVAL);
  localparam logic [SI_BIT-1:0]    CNT_1 = SI_BIT'(1);

  logic [2:0]           r_state, w_state_nxt;
  logic [DEPTH_BIT-1:0] r_pos, w_pos_nxt, w_pos_inc;
  logic [SI_BIT-1:0]    r_cnt, w_cnt_nxt;
  logic                 r_full, w_full_nxt;
  logic                 r_done, w_done_nxt;
  logic                 w_wrap, w_last;

  assign w_pos_inc = r_pos + 1'b1;
  assign w_wrap    = (r_cnt == SI_V);
  assign w_last    = (w_pos_inc == mem_duration);

  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_cnt_nxt   = r_cnt;
    w_full_nxt  = r_full;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (clear_btn) w_state_nxt = S_CLEAR;
        else if (stop_btn) w_state_nxt = S_IDLE;
        else if (rec_btn) begin
          if (mem_duration < MAX_D) w_state_nxt = S_RECORD;
          else                      w_full_nxt  = 1'b1;
        end
        else if (play_btn && mem_duration != '0) w_state_nxt = S_REWIND;
      end
      S_RECORD: begin
        // capacity takes precedence over any button in the same cycle
        if (mem_duration >= MAX_D) begin
          w_state_nxt = S_IDLE;
          w_full_nxt  = 1'b1;
        end
        else if (clear_btn)           w_state_nxt = S_CLEAR;
        else if (stop_btn || rec_btn) w_state_nxt = S_IDLE;
      end
      S_REWIND: begin
        w_pos_nxt   = '0;
        w_cnt_nxt   = CNT_1;
        w_state_nxt = S_PLAY;
      end
      S_PLAY: begin
        // counter tracks the memory read pointer every PLAY cycle, buttons or not
        if (w_wrap) begin
          w_cnt_nxt = CNT_1;
          if (!w_last) w_pos_nxt = w_pos_inc;
        end
        else w_cnt_nxt = r_cnt + 1'b1;
        if (clear_btn)     w_state_nxt = S_CLEAR;
        else if (stop_btn) w_state_nxt = S_IDLE;
        else if (play_btn) w_state_nxt = S_PAUSE;
        else if (w_wrap && w_last) begin
          if (loop_en) w_state_nxt = S_REWIND;
          else begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      S_PAUSE: begin
        if (clear_btn)     w_state_nxt = S_CLEAR;
        else if (stop_btn) w_state_nxt = S_IDLE;
        else if (play_btn) w_state_nxt = S_PLAY;
      end
      S_CLEAR: begin
        w_full_nxt  = 1'b0;
        w_pos_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pos   <= '0;
      r_cnt   <= CNT_1;
      r_full  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pos   <= w_pos_nxt;
      r_cnt   <= w_cnt_nxt;
      r_full  <= w_full_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign mem_write_en = (r_state == S_RECORD);
  assign mem_read_en  = (r_state == S_PLAY);
  assign mem_read_rst = (r_state == S_REWIND);
  assign mem_clear_n  = ~(r_state == S_CLEAR);
  assign state        = r_state;
  assign play_pos     = r_pos;
  assign rec_full     = r_full;
  assign play_done    = r_done;

endmodule
